// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the serial configuration-frame loader.
//   - default geometry (sites, address width, payload width)
//   - FRAME_BITS: serial bits per frame (address + data + parity)
//   - receive FSM state encoding
//   - even-parity helper
package cfg_loader_pkg;

    localparam int DEF_N_SITES = 5;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_CFG_W   = 4;
    localparam int FRAME_BITS  = DEF_ADDR_W + DEF_CFG_W + 1;

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PAR    = 2'd2,
        ST_COMMIT = 2'd3
    } rx_state_t;

    // True when the supplied bit vector has an even number of ones.
    function automatic logic even_parity_ok(input logic [31:0] bits);
        return ~(^bits);
    endfunction

endpackage

// File: rtl/cfg_shift_rx.sv
// Serial frame receiver: shifts in address/data/parity MSB first, tracks the
// running parity and handles the valid/ready handshake and CFG_SYNC restart.
// Ports:
//   clk, rst          clock, async active-high reset
//   cfg_valid/cfg_bit serial input qualified by cfg_valid
//   cfg_sync          frame restart (ignored while committing)
//   cfg_ready         bit accepted this cycle when high
//   frame_addr/data   assembled fields, valid while frame_complete is high
//   parity_ok         whole frame has even parity (with the parity bit on cfg_bit)
//   frame_complete    parity bit handshake happening this cycle
//
// state     | meaning
// ST_ADDR   | shifting address bits
// ST_DATA   | shifting payload bits
// ST_PAR    | waiting for the parity bit
// ST_COMMIT | one cycle while the top commits the frame, not ready
module cfg_shift_rx
    import cfg_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CFG_W  = DEF_CFG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    input  logic              cfg_sync,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [CFG_W-1:0]  frame_data,
    output logic              parity_ok,
    output logic              frame_complete
);

    localparam int SH_W      = ADDR_W + CFG_W;
    localparam int MAX_FIELD = (ADDR_W > CFG_W) ? ADDR_W : CFG_W;
    localparam int CNT_W     = $clog2(MAX_FIELD + 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    assign cfg_ready      = (state_q != ST_COMMIT);
    assign fire           = cfg_valid & cfg_ready;
    assign frame_addr     = shreg_q[SH_W-1 -: ADDR_W];
    assign frame_data     = shreg_q[CFG_W-1:0];
    assign parity_ok      = even_parity_ok(32'({par_q, cfg_bit}));
    assign frame_complete = (state_q == ST_PAR) & fire & ~cfg_sync;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        // A restart wins over a handshake except while committing, so a
        // frame that already delivered its parity bit is never lost.
        if (cfg_sync && state_q != ST_COMMIT) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            shreg_d = '0;
            par_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_DATA: begin
                    if (fire) begin
                        shreg_d = {shreg_q[SH_W-2:0], cfg_bit};
                        par_d   = par_q ^ cfg_bit;
                        cnt_d   = cnt_q + 1'b1;
                        if (state_q == ST_ADDR && cnt_q == CNT_W'(ADDR_W - 1)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                        end else if (state_q == ST_DATA && cnt_q == CNT_W'(CFG_W - 1)) begin
                            state_d = ST_PAR;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_PAR: begin
                    if (fire) begin
                        state_d = ST_COMMIT;
                        shreg_d = '0;
                        par_d   = 1'b0;
                    end
                end
                default: state_d = ST_ADDR;
            endcase
        end
    end

endmodule

// File: rtl/cfg_frame_loader.sv
// Serial configuration-frame loader. Each accepted frame writes one site's
// configuration slice and marks the site as loaded.
// Ports:
//   CLK, RST         clock, async active-high reset
//   CFG_VALID/BIT    serial frame bit and its qualifier
//   CFG_READY        loader accepts a bit this cycle
//   CFG_SYNC         restart frame, drop partial bits
//   CFG_O            site k configuration at [k*CFG_W +: CFG_W]
//   SITE_LOADED      sticky per-site written flag
//   LOAD_DONE        pulse on accepted frame
//   LOAD_ERR         pulse on rejected frame (bad parity or address)
module cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int N_SITES = DEF_N_SITES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CFG_W   = DEF_CFG_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CFG_VALID,
    input  logic                     CFG_BIT,
    output logic                     CFG_READY,
    input  logic                     CFG_SYNC,
    output logic [N_SITES*CFG_W-1:0] CFG_O,
    output logic [N_SITES-1:0]       SITE_LOADED,
    output logic                     LOAD_DONE,
    output logic                     LOAD_ERR
);

    logic [ADDR_W-1:0]        frame_addr;
    logic [CFG_W-1:0]         frame_data;
    logic                     parity_ok;
    logic                     frame_complete;
    logic                     in_range;

    logic [N_SITES*CFG_W-1:0] cfg_q, cfg_d;
    logic [N_SITES-1:0]       loaded_q, loaded_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    cfg_shift_rx #(
        .ADDR_W (ADDR_W),
        .CFG_W  (CFG_W)
    ) u_rx (
        .clk            (CLK),
        .rst            (RST),
        .cfg_valid      (CFG_VALID),
        .cfg_bit        (CFG_BIT),
        .cfg_sync       (CFG_SYNC),
        .cfg_ready      (CFG_READY),
        .frame_addr     (frame_addr),
        .frame_data     (frame_data),
        .parity_ok      (parity_ok),
        .frame_complete (frame_complete)
    );

    // Extra bit so the compare also works when N_SITES == 2**ADDR_W.
    assign in_range = ({1'b0, frame_addr} < (ADDR_W + 1)'(N_SITES));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg_q    <= '0;
            loaded_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        cfg_d    = cfg_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (frame_complete) begin
            if (parity_ok && in_range) begin
                done_d = 1'b1;
                for (int k = 0; k < N_SITES; k++) begin
                    if (frame_addr == ADDR_W'(k)) begin
                        cfg_d[k*CFG_W +: CFG_W] = frame_data;
                        loaded_d[k]             = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign CFG_O       = cfg_q;
    assign SITE_LOADED = loaded_q;
    assign LOAD_DONE   = done_q;
    assign LOAD_ERR    = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: frames are driven bit-serially; the expected
// commit outcome is pushed to a scoreboard when the parity bit is driven and
// popped when LOAD_DONE/LOAD_ERR appears.
module tb_cfg_frame_loader;
    import cfg_loader_pkg::*;

    logic        CLK, RST;
    logic        CFG_VALID, CFG_BIT, CFG_SYNC;
    logic        CFG_READY;
    logic [19:0] CFG_O;
    logic [4:0]  SITE_LOADED;
    logic        LOAD_DONE, LOAD_ERR;

    cfg_frame_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .CFG_VALID   (CFG_VALID),
        .CFG_BIT     (CFG_BIT),
        .CFG_READY   (CFG_READY),
        .CFG_SYNC    (CFG_SYNC),
        .CFG_O       (CFG_O),
        .SITE_LOADED (SITE_LOADED),
        .LOAD_DONE   (LOAD_DONE),
        .LOAD_ERR    (LOAD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        done;
        logic        err;
        logic [19:0] cfg;
        logic [4:0]  loaded;
    } exp_t;

    exp_t        sb_q[$];
    logic [19:0] m_cfg;
    logic [4:0]  m_loaded;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic        pulse_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [2:0] addr, input logic [3:0] data);
        return ^{addr, data};
    endfunction

    // Expected result of a complete frame, computed from the frame contents.
    task automatic push_expect(input logic [2:0] addr, input logic [3:0] data, input logic par);
        exp_t e;
        logic ok;
        ok = (^{addr, data, par} == 1'b0) && (addr < 3'd5);
        if (ok) begin
            m_cfg[addr*4 +: 4] = data;
            m_loaded[addr]     = 1'b1;
        end
        e.done   = ok;
        e.err    = !ok;
        e.cfg    = m_cfg;
        e.loaded = m_loaded;
        sb_q.push_back(e);
    endtask

    // Drive the first nbits of a frame; one gap of gap_len idle cycles with
    // garbage on CFG_BIT is inserted before bit gap_at.
    task automatic send_frame(input logic [2:0] addr, input logic [3:0] data, input logic par,
                              input int gap_at, input int gap_len, input int nbits);
        logic [7:0] frm;
        int waited;
        frm = {addr, data, par};
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(negedge CLK);
                    CFG_VALID = 1'b0;
                    CFG_BIT   = 1'($urandom);
                end
            end
            @(negedge CLK);
            CFG_VALID = 1'b1;
            CFG_BIT   = frm[7-i];
            waited    = 0;
            while (!CFG_READY && waited < 20) begin
                @(negedge CLK);
                waited++;
            end
            if (waited >= 20) check("ready_timeout", 32'(CFG_READY), 32'd1);
            if (i == FRAME_BITS - 1) push_expect(addr, data, par);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            CFG_VALID = 1'b0;
            CFG_BIT   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        CFG_VALID = 1'b0;
        CFG_SYNC  = 1'b0;
        m_cfg     = '0;
        m_loaded  = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Scoreboard consumer and pulse-shape checks.
    always @(negedge CLK) begin
        if (RST) begin
            pulse_prev <= 1'b0;
        end else begin
            if (pulse_prev) begin
                check("ready_after_commit", 32'(CFG_READY), 32'd1);
                check("pulse_width", 32'({LOAD_DONE, LOAD_ERR}), 32'd0);
            end
            if (LOAD_DONE || LOAD_ERR) begin
                if (LOAD_DONE) done_cnt++;
                if (LOAD_ERR)  err_cnt++;
                check("ready_in_commit", 32'(CFG_READY), 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", 32'({LOAD_DONE, LOAD_ERR}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("load_done", 32'(LOAD_DONE), 32'(e.done));
                    check("load_err", 32'(LOAD_ERR), 32'(e.err));
                    check("cfg_o", 32'(CFG_O), 32'(e.cfg));
                    check("site_loaded", 32'(SITE_LOADED), 32'(e.loaded));
                end
            end
            pulse_prev <= LOAD_DONE | LOAD_ERR;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, e0, gap_pos;
        RST = 1'b1; CFG_VALID = 1'b0; CFG_BIT = 1'b0; CFG_SYNC = 1'b0;
        m_cfg = '0; m_loaded = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_cfg_o", 32'(CFG_O), 32'd0);
        check("rst_loaded", 32'(SITE_LOADED), 32'd0);
        check("rst_pulses", 32'({LOAD_DONE, LOAD_ERR}), 32'd0);
        check("rst_ready", 32'(CFG_READY), 32'd1);

        // Basic write: site 2 <= 0xA
        send_frame(3'b010, 4'b1010, 1'b1, -1, 0, FRAME_BITS);
        idle(3);
        check("basic_cfg", 32'(CFG_O), 32'h00A00);
        check("basic_loaded", 32'(SITE_LOADED), 32'b00100);

        // Bad parity on site 1: rejected, nothing written
        d0 = done_cnt; e0 = err_cnt;
        send_frame(3'b001, 4'b0011, ~good_par(3'b001, 4'b0011), -1, 0, FRAME_BITS);
        idle(3);
        check("badpar_err", 32'(err_cnt - e0), 32'd1);
        check("badpar_cfg", 32'(CFG_O), 32'h00A00);

        // Out-of-range address with good parity
        d0 = done_cnt; e0 = err_cnt;
        send_frame(3'b111, 4'b1111, 1'b1, -1, 0, FRAME_BITS);
        idle(3);
        check("oor_err", 32'(err_cnt - e0), 32'd1);
        check("oor_done", 32'(done_cnt - d0), 32'd0);
        check("oor_loaded", 32'(SITE_LOADED), 32'b00100);

        // Gapped VALID then back-to-back frame, from a clean reset
        do_reset();
        d0 = done_cnt;
        gap_pos = $urandom_range(1, FRAME_BITS - 2);
        send_frame(3'd4, 4'h5, good_par(3'd4, 4'h5), gap_pos, 3, FRAME_BITS);
        send_frame(3'd0, 4'hC, good_par(3'd0, 4'hC), -1, 0, FRAME_BITS);
        idle(3);
        check("b2b_cfg", 32'(CFG_O), 32'h5000C);
        check("b2b_loaded", 32'(SITE_LOADED), 32'b10001);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);

        // CFG_SYNC after 2 data bits, then a full frame to site 1
        d0 = done_cnt; e0 = err_cnt;
        send_frame(3'd3, 4'hF, 1'b0, -1, 0, 5);
        @(negedge CLK);
        CFG_SYNC = 1'b1; CFG_VALID = 1'b1; CFG_BIT = 1'b1;
        @(negedge CLK);
        CFG_SYNC = 1'b0; CFG_VALID = 1'b0;
        send_frame(3'd1, 4'h7, good_par(3'd1, 4'h7), -1, 0, FRAME_BITS);
        idle(3);
        check("sync_site1", 32'(CFG_O[7:4]), 32'h7);
        check("sync_cfg", 32'(CFG_O), 32'h5007C);
        check("sync_done", 32'(done_cnt - d0), 32'd1);
        check("sync_err", 32'(err_cnt - e0), 32'd0);

        // Re-write site 0: slice overwritten, flag stays set
        send_frame(3'd0, 4'h3, good_par(3'd0, 4'h3), -1, 0, FRAME_BITS);
        idle(3);
        check("rewrite_cfg", 32'(CFG_O), 32'h50073);
        check("rewrite_loaded", 32'(SITE_LOADED), 32'b10011);

        // Asynchronous reset mid-frame after site 2 was loaded
        do_reset();
        send_frame(3'd2, 4'h9, good_par(3'd2, 4'h9), -1, 0, FRAME_BITS);
        idle(3);
        check("pre_rst_cfg", 32'(CFG_O), 32'h00900);
        send_frame(3'd3, 4'h6, 1'b0, -1, 0, 4);
        @(negedge CLK);
        CFG_VALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("async_cfg", 32'(CFG_O), 32'd0);
        check("async_loaded", 32'(SITE_LOADED), 32'd0);
        check("async_pulses", 32'({LOAD_DONE, LOAD_ERR}), 32'd0);
        check("async_ready", 32'(CFG_READY), 32'd1);
        m_cfg = '0; m_loaded = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        send_frame(3'd3, 4'h6, good_par(3'd3, 4'h6), -1, 0, FRAME_BITS);
        idle(3);
        check("post_rst_cfg", 32'(CFG_O), 32'h06000);
        check("post_rst_loaded", 32'(SITE_LOADED), 32'b01000);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
